// File: rtl/sync_fifo_pkg.sv
// Shared constants, width helper and status bundle for the operand FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 4;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Push/pop handshake and status bundle between a PE port and the operand FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_W      = addr_w(DEF_DEPTH) + 1
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output push, push_data, pop, err_clr,
    input  pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, err_clr,
    output pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_up_down_counter.sv
// Occupancy counter: steps up on inc, down on dec, holds when both or neither.
module fifo_up_down_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned INC_STEP = 1,
  parameter int unsigned DEC_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   count <= count + WIDTH'(INC_STEP);
        2'b01:   count <= count - WIDTH'(DEC_STEP);
        2'b11:   count <= count + WIDTH'(INC_STEP) - WIDTH'(DEC_STEP);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word fall-through operand FIFO updating on the falling clock edge,
// with occupancy-derived status flags and sticky overflow/underflow errors.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH           = DEF_DEPTH,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input logic       clk,
  input logic       reset,
  sync_fifo_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = addr_w(DEPTH);
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  overflow;
  logic                  underflow;
  fifo_status_t          status;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_acc  = bus.pop && !status.empty;
  assign push_acc = bus.push && (!status.full || pop_acc);

  fifo_up_down_counter #(
    .WIDTH    (CNT_W),
    .INC_STEP (1),
    .DEC_STEP (1)
  ) u_occupancy (
    .clk   (clk),
    .reset (reset),
    .inc   (push_acc),
    .dec   (pop_acc),
    .count (count)
  );

  assign status.full         = (count == CNT_W'(DEPTH));
  assign status.empty        = (count == '0);
  assign status.almost_full  = (count >= CNT_W'(ALMOST_FULL_TH));
  assign status.almost_empty = (count <= CNT_W'(ALMOST_EMPTY_TH));

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      // A fresh rejection outranks a simultaneous clear.
      if (bus.push && !push_acc) overflow <= 1'b1;
      else if (bus.err_clr)      overflow <= 1'b0;
      if (bus.pop && !pop_acc)   underflow <= 1'b1;
      else if (bus.err_clr)      underflow <= 1'b0;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(negedge clk) begin
    if (push_acc) mem[wr_ptr] <= bus.push_data;
  end

  assign bus.pop_data     = mem[rd_ptr];
  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          model_ovf = 1'b0;
  logic          model_unf = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive after the rising edge, apply the reference rules after the falling edge.
  task automatic cycle(input logic p, input logic [DW-1:0] d, input logic q, input logic clr);
    bit pa, qa;
    @(posedge clk);
    #1;
    bus.push = p; bus.push_data = d; bus.pop = q; bus.err_clr = clr;
    if (q && model_q.size() > 0) exp_q.push_back(model_q[0]);
    @(negedge clk);
    #1;
    qa = q && (model_q.size() > 0);
    pa = p && ((model_q.size() < DEPTH) || qa);
    if (qa) void'(model_q.pop_front());
    if (pa) model_q.push_back(d);
    if (p && !pa) model_ovf = 1'b1; else if (clr) model_ovf = 1'b0;
    if (q && !qa) model_unf = 1'b1; else if (clr) model_unf = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    #3;
    reset = 1'b0;
  endtask

  // Monitor: status against the model every cycle, popped words against the scoreboard.
  initial begin
    logic [AW-1:0] diff;
    int            inv;
    forever begin
      @(posedge clk);
      #3;
      chk("count", 32'(bus.count), 32'(model_q.size()));
      chk("full", 32'(bus.full), 32'(model_q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(model_q.size() >= DEPTH - 1));
      chk("almost_empty", 32'(bus.almost_empty), 32'(model_q.size() <= 1));
      chk("overflow", 32'(bus.overflow), 32'(model_ovf));
      chk("underflow", 32'(bus.underflow), 32'(model_unf));
      diff = dut.wr_ptr - dut.rd_ptr;
      inv  = (diff == '0 && model_q.size() == DEPTH) ? DEPTH : int'(diff);
      chk("ptr_invariant", 32'(bus.count), 32'(inv));
      if (model_q.size() > 0) chk("head", 32'(bus.pop_data), 32'(model_q[0]));
      if (bus.pop && !bus.empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data: unexpected pop, got 0x%0h expected none", bus.pop_data);
        end else begin
          chk("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] rd_save;
    logic [AW-1:0] wr_save;
    logic [DW-1:0] drain [4];
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    drain[0] = 16'hA002; drain[1] = 16'hA003; drain[2] = 16'hA004; drain[3] = 16'hC000;
    #22 reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DW'(16'hA001 + i), 1'b0, 1'b0);
      chk("head_a001", 32'(bus.pop_data), 32'h0000A001);
      if (i == 2) begin
        chk("cnt3", 32'(bus.count), 3);
        chk("af3", 32'(bus.almost_full), 1);
      end
    end
    chk("full4", 32'(bus.full), 1);

    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("cnt_full", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_a", 32'(bus.pop_data), 32'(16'hA001 + i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("empty_after", 32'(bus.empty), 1);

    rd_save = dut.rd_ptr;
    wr_save = dut.wr_ptr;
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_cnt", 32'(bus.count), 0);
    chk("rd_hold", 32'(dut.rd_ptr), 32'(rd_save));
    chk("wr_hold", 32'(dut.wr_ptr), 32'(wr_save));
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_unf", 32'(bus.underflow), 0);

    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'hA001 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'hC000, 1'b1, 1'b0);
    chk("both_cnt", 32'(bus.count), 4);
    chk("both_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_wrap", 32'(bus.pop_data), 32'(drain[i]));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end

    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("nobypass_unf", 32'(bus.underflow), 1);
    chk("nobypass_cnt", 32'(bus.count), 1);
    chk("nobypass_data", 32'(bus.pop_data), 32'h00001234);
    cycle(1'b0, '0, 1'b1, 1'b1);

    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h7000 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    cycle(1'b1, 16'h7778, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 16'h5678, 1'b0, 1'b0);
    chk("post_rst_head", 32'(bus.pop_data), 32'h00005678);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(bus.empty), 1);

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
      if (n == 200) begin
        for (int k = 0; k < 2; k++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        async_reset();
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    @(posedge clk);
    #4;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
